// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch path: state encoding,
// instruction width, default queue depth and the queue entry layout.
package fetch_unit_pkg;

  localparam int INSN_W      = 32;
  localparam int FETCH_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSN_W-1:0] insn;
    logic [31:0]       pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue: DEPTH x 64-bit circular buffer with extended pointers
// and a synchronous flush that wins over same-cycle push/pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_data,
  output logic [AW:0]  o_count,
  output logic         o_empty
);

  fetch_entry_t r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (o_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word request at a time into a
// prefetch queue, with redirect flush and discard of in-flight data.
//   state     | meaning
//   S_IDLE    | no request outstanding
//   S_WAIT    | request outstanding, data will be queued
//   S_DISCARD | request outstanding, data will be dropped (redirected)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [7:0]        mem_addr,
  input  logic              mem_ack,
  input  logic [INSN_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              insn_valid,
  output logic [INSN_W-1:0] insn,
  output logic [31:0]       insn_pc,
  input  logic              insn_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e r_state;
  logic         r_mem_req;
  logic [7:0]   r_mem_addr;
  logic [31:0]  r_fetch_pc;

  logic         w_push;
  logic         w_pop;
  logic         w_empty;
  logic         w_space;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  logic [31:0]  w_pc_inc;
  fetch_entry_t w_wr_entry;
  fetch_entry_t w_head;

  assign w_pop        = !w_empty && insn_ready && !redirect;
  assign w_push       = (r_state == S_WAIT) && mem_ack && !redirect;
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
  // The slot for a new request is reserved against the post-edge count.
  assign w_space      = (w_count_next < CW'(DEPTH));
  assign w_pc_inc     = r_fetch_pc + 32'd1;
  assign w_wr_entry   = '{insn: mem_rdata, pc: r_fetch_pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_wr_entry),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC[7:0];
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      if (r_state != S_IDLE && !mem_ack) begin
        r_state   <= S_DISCARD;
        r_mem_req <= 1'b1;
      end else begin
        r_state    <= S_IDLE;
        r_mem_req  <= 1'b0;
        r_mem_addr <= redirect_pc[7:0];
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_space) begin
            r_state   <= S_WAIT;
            r_mem_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_fetch_pc <= w_pc_inc;
            r_mem_addr <= w_pc_inc[7:0];
            if (!w_space) begin
              r_state   <= S_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (mem_ack) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= r_fetch_pc[7:0];
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign insn_valid = !w_empty;
  assign insn       = w_empty ? '0 : w_head.insn;
  assign insn_pc    = w_empty ? '0 : w_head.pc;

endmodule
